mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 16, memory word width in bits.
REQ-002 Parameter ADDR_W, default 8, word address width; depth is 2**ADDR_W words.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15, number of wait-state cycles before the response.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 MemRead  input  1  level read request from the control FSM.
REQ-007 Memwrite  input  1  level write request from the control FSM.
REQ-008 IorD  input  1  access type: 0 = instruction fetch, 1 = data; used only for the fetch counter.
REQ-009 addr  input  ADDR_W  word address, sampled at request accept.
REQ-010 wdata  input  DATA_W  write data, sampled at request accept.
REQ-011 rdata  output  DATA_W  read data; holds the last completed read value.
REQ-012 mem_ready  output  1  one-cycle completion pulse.
REQ-013 mem_busy  output  1  high from accept through response.
REQ-014 mem_err  output  1  sticky flag: read and write were requested together.
REQ-015 fetch_cnt  output  16  count of completed reads with IorD=0; wraps.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP, DONE.
REQ-017 IDLE: if MemRead or Memwrite is high, SHALL latch addr, wdata, IorD and op, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-018 WAIT: a 4-bit counter SHALL load WAIT_CYCLES-1 at accept and decrement each cycle; go to RESP when it reaches 0.
REQ-019 RESP lasts exactly one cycle: mem_ready=1; a read updates rdata from the array at the latched address in the same cycle; a write updates the array at the latched address with the latched data.
REQ-020 Latency: accept edge to mem_ready high = WAIT_CYCLES+1 cycles.
REQ-021 DONE: SHALL stay until MemRead=0 and Memwrite=0, then go to IDLE; held level strobes never re-trigger an access.
REQ-022 Strobes, addr and wdata changes during WAIT, RESP or DONE SHALL be ignored.
REQ-023 If MemRead and Memwrite are both high at accept: no array access, rdata unchanged, mem_err set, the normal WAIT/RESP/DONE timing is kept, and mem_ready still pulses.
REQ-024 mem_busy=1 in WAIT and RESP, 0 in IDLE and DONE.
REQ-025 fetch_cnt SHALL increment in RESP for a successful read with latched IorD=0, and wrap from 0xFFFF to 0.
REQ-026 Read-after-write to the same address on consecutive transactions SHALL return the new data.

Reset
REQ-027 Asserting reset (low) SHALL immediately force: state IDLE, wait counter 0, rdata 0, mem_ready 0, mem_busy 0, mem_err 0, fetch_cnt 0.
REQ-028 Array contents SHALL NOT be cleared by reset.
REQ-029 Reset in the middle of a write SHALL abort it with no array update unless RESP has already been clocked.
REQ-030 After reset is released, the first edge with a strobe high SHALL be accepted, even if the strobe stayed high through reset.

Structure
REQ-031 Package mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP, DONE), the op encoding (RD, WR, ERR) and the DATA_W/ADDR_W defaults.
REQ-032 One sub-module mem_array SHALL hold the storage: synchronous write, combinational read, no reset.

Verification
REQ-033 WAIT_CYCLES=2: write 0xBEEF to addr 0x10, release strobe, then read 0x10 -> each mem_ready appears 3 cycles after accept; rdata=0xBEEF.
REQ-034 MemRead held high for 10 cycles with IorD=0 -> exactly one mem_ready pulse; fetch_cnt increments by 1.
REQ-035 MemRead=Memwrite=1 at accept -> mem_err=1 stays set; rdata unchanged; array at addr unchanged; mem_ready pulses once.
REQ-036 WAIT_CYCLES=0: read addr 0xFF -> mem_ready on the cycle after accept; addr changed during DONE has no effect.
REQ-037 Reset asserted in WAIT of a write of 0x1234 to 0x20 -> all outputs 0 immediately; later read of 0x20 returns the old value.
REQ-038 Preload fetch_cnt to 0xFFFF via 65535 fetches (or force), then one more fetch -> fetch_cnt=0x0000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state memory responder.
// Holds the FSM state encoding, the latched operation encoding and width defaults.
package mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RD,
        WR,
        ERR
    } op_t;

    // Both strobes together is a protocol error, not a write.
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr) begin
            return ERR;
        end
        if (wr) begin
            return WR;
        end
        return RD;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage for mem_responder.
// Synchronous write, combinational read, single shared address.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage deliberately has no reset; contents must survive a reset of the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder with a fixed number of wait states per access.
// Accepts a level read/write request, answers with a one-cycle mem_ready pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              Memwrite,
    input  logic              IorD,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err,
    output logic [15:0]       fetch_cnt
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_nxt;
    op_t               op;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              iord_q;
    logic              accept;
    logic              array_we;
    logic [DATA_W-1:0] array_rdata;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        mem_ready    = 1'b0;
        mem_busy     = 1'b0;
        array_we     = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead || Memwrite) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                mem_busy  = 1'b1;
                mem_ready = 1'b1;
                array_we  = (op == WR);
                state_nxt = DONE;
            end
            DONE: begin
                // Held strobes park here so a level request is served only once.
                if (!MemRead && !Memwrite) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            op        <= RD;
            addr_q    <= '0;
            wdata_q   <= '0;
            iord_q    <= 1'b0;
            rdata     <= '0;
            mem_err   <= 1'b0;
            fetch_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                op      <= decode_op(MemRead, Memwrite);
                addr_q  <= addr;
                wdata_q <= wdata;
                iord_q  <= IorD;
                if (MemRead && Memwrite) begin
                    mem_err <= 1'b1;
                end
            end
            if (state == RESP && op == RD) begin
                rdata <= array_rdata;
                if (!iord_q) begin
                    fetch_cnt <= fetch_cnt + 16'd1;
                end
            end
        end
    end

    mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (array_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(array_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states, one with none.
// Stimulus pushes hand-computed responses; per-instance monitors pop them on mem_ready.
module tb_mem_responder;

    localparam int WC0 = 2;
    localparam int WC1 = 0;

    typedef struct {
        int          due;
        bit          chk_rd;
        logic [15:0] rdata;
        logic        err;
        logic [15:0] fetch;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read  [2];
    logic        mem_write [2];
    logic        iord      [2];
    logic [7:0]  addr      [2];
    logic [15:0] wdata     [2];
    logic [15:0] rdata     [2];
    logic        ready     [2];
    logic        busy      [2];
    logic        err       [2];
    logic [15:0] fetch_cnt [2];

    exp_t sb [2][$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(WC0)) u_dut0 (
        .clk(clk), .reset(reset), .MemRead(mem_read[0]), .Memwrite(mem_write[0]),
        .IorD(iord[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .mem_ready(ready[0]), .mem_busy(busy[0]), .mem_err(err[0]), .fetch_cnt(fetch_cnt[0])
    );

    mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(WC1)) u_dut1 (
        .clk(clk), .reset(reset), .MemRead(mem_read[1]), .Memwrite(mem_write[1]),
        .IorD(iord[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .mem_ready(ready[1]), .mem_busy(busy[1]), .mem_err(err[1]), .fetch_cnt(fetch_cnt[1])
    );

    function automatic int wc_of(input int u);
        return (u == 0) ? WC0 : WC1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response latency counts from the negedge the request is driven to the negedge mem_ready is seen.
    task automatic monitor(input int u);
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready[u]) begin
                if (sb[u].size() == 0) begin
                    check($sformatf("u%0d_spurious_ready", u), 32'(ready[u]), 32'd0);
                end else begin
                    e = sb[u][0];
                    check($sformatf("u%0d_latency", u), cyc, e.due);
                    check($sformatf("u%0d_busy_at_ready", u), 32'(busy[u]), 32'd1);
                    @(negedge clk);
                    check($sformatf("u%0d_ready_one_cycle", u), 32'(ready[u]), 32'd0);
                    if (e.chk_rd) begin
                        check($sformatf("u%0d_rdata", u), 32'(rdata[u]), 32'(e.rdata));
                    end
                    check($sformatf("u%0d_err", u), 32'(err[u]), 32'(e.err));
                    check($sformatf("u%0d_fetch_cnt", u), 32'(fetch_cnt[u]), 32'(e.fetch));
                    void'(sb[u].pop_front());
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_idle(input int u);
        int n = 0;
        while ((sb[u].size() != 0 || busy[u]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_drain", u), 32'(sb[u].size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Drive one request, hold it for `hold` cycles while scrambling addr/wdata, then drop it.
    task automatic issue(input int u, input bit rd, input bit wr, input bit io,
                         input logic [7:0] a, input logic [15:0] d, input int hold,
                         input bit chk_rd, input logic [15:0] exp_rd,
                         input logic exp_err, input logic [15:0] exp_fetch);
        exp_t e;
        @(negedge clk);
        mem_read[u]  = rd;
        mem_write[u] = wr;
        iord[u]      = io;
        addr[u]      = a;
        wdata[u]     = d;
        e.due    = cyc + wc_of(u) + 1;
        e.chk_rd = chk_rd;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.fetch  = exp_fetch;
        sb[u].push_back(e);
        repeat (hold) begin
            @(negedge clk);
            addr[u]  = a ^ 8'h01;
            wdata[u] = ~d;
        end
        mem_read[u]  = 1'b0;
        mem_write[u] = 1'b0;
        wait_idle(u);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            mem_read[u]  = 1'b0;
            mem_write[u] = 1'b0;
            iord[u]      = 1'b0;
            addr[u]      = 8'h00;
            wdata[u]     = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_reset_rdata", u), 32'(rdata[u]), 32'd0);
            check($sformatf("u%0d_reset_ready", u), 32'(ready[u]), 32'd0);
            check($sformatf("u%0d_reset_busy", u), 32'(busy[u]), 32'd0);
            check($sformatf("u%0d_reset_err", u), 32'(err[u]), 32'd0);
            check($sformatf("u%0d_reset_fetch", u), 32'(fetch_cnt[u]), 32'd0);
        end
        reset = 1'b1;

        // Two wait states: write/read, held fetch, ignored mid-flight changes, error, RAW.
        issue(0, 0, 1, 1, 8'h10, 16'hBEEF, 1,  0, 16'h0000, 0, 16'd0);
        issue(0, 1, 0, 1, 8'h10, 16'h0000, 1,  1, 16'hBEEF, 0, 16'd0);
        issue(0, 1, 0, 0, 8'h10, 16'h0000, 10, 1, 16'hBEEF, 0, 16'd1);
        issue(0, 0, 1, 1, 8'h20, 16'h5555, 1,  0, 16'h0000, 0, 16'd1);
        issue(0, 0, 1, 1, 8'h31, 16'h3131, 1,  0, 16'h0000, 0, 16'd1);
        issue(0, 0, 1, 1, 8'h30, 16'h0A0A, 1,  0, 16'h0000, 0, 16'd1);
        issue(0, 1, 0, 1, 8'h31, 16'h0000, 1,  1, 16'h3131, 0, 16'd1);
        issue(0, 1, 0, 0, 8'h30, 16'h0000, 1,  1, 16'h0A0A, 0, 16'd2);
        issue(0, 1, 1, 0, 8'h10, 16'h1111, 1,  1, 16'h0A0A, 1, 16'd2);
        issue(0, 1, 0, 1, 8'h10, 16'h0000, 1,  1, 16'hBEEF, 1, 16'd2);
        issue(0, 0, 1, 1, 8'h10, 16'h2222, 1,  0, 16'h0000, 1, 16'd2);
        issue(0, 1, 0, 1, 8'h10, 16'h0000, 1,  1, 16'h2222, 1, 16'd2);

        // Reset while a write of 0x1234 to 0x20 sits in WAIT.
        @(negedge clk);
        mem_write[0] = 1'b1;
        iord[0]      = 1'b1;
        addr[0]      = 8'h20;
        wdata[0]     = 16'h1234;
        @(negedge clk);
        mem_write[0] = 1'b0;
        check("u0_busy_before_abort", 32'(busy[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("u0_abort_rdata", 32'(rdata[0]), 32'd0);
        check("u0_abort_ready", 32'(ready[0]), 32'd0);
        check("u0_abort_busy", 32'(busy[0]), 32'd0);
        check("u0_abort_err", 32'(err[0]), 32'd0);
        check("u0_abort_fetch", 32'(fetch_cnt[0]), 32'd0);
        mem_read[0] = 1'b1;
        iord[0]     = 1'b0;
        addr[0]     = 8'h20;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        e.due    = cyc + WC0 + 1;
        e.chk_rd = 1'b1;
        e.rdata  = 16'h5555;
        e.err    = 1'b0;
        e.fetch  = 16'd1;
        sb[0].push_back(e);
        @(negedge clk);
        mem_read[0] = 1'b0;
        addr[0]     = 8'h21;
        wait_idle(0);

        // Zero wait states: addr change in RESP/DONE, error keeps array, fetch wrap.
        issue(1, 0, 1, 1, 8'hFF, 16'hA5A5, 1, 0, 16'h0000, 0, 16'd0);
        issue(1, 0, 1, 1, 8'hFE, 16'h0101, 1, 0, 16'h0000, 0, 16'd0);
        issue(1, 1, 0, 0, 8'hFF, 16'h0000, 6, 1, 16'hA5A5, 0, 16'd1);
        check("u1_rdata_after_done", 32'(rdata[1]), 32'hA5A5);
        issue(1, 1, 0, 1, 8'hFE, 16'h0000, 1, 1, 16'h0101, 0, 16'd1);
        issue(1, 1, 1, 0, 8'hFF, 16'h9999, 1, 1, 16'h0101, 1, 16'd1);
        issue(1, 1, 0, 1, 8'hFF, 16'h0000, 1, 1, 16'hA5A5, 1, 16'd1);

        @(negedge clk);
        force u_dut1.fetch_cnt = 16'hFFFF;
        @(negedge clk);
        release u_dut1.fetch_cnt;
        @(negedge clk);
        check("u1_fetch_preload", 32'(fetch_cnt[1]), 32'hFFFF);
        issue(1, 1, 0, 0, 8'hFF, 16'h0000, 1, 1, 16'hA5A5, 1, 16'd0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
